iq_sample_unpacker: RTL

- Converts the interleaved front-end sample stream into parallel per-channel I/Q frames for acquisition.
- Input word order is ch0 I, ch0 Q, ch1 I, ch1 Q, ... with optional byte reversal per word.
- Generalises the single-channel fixed-16-bit I/Q alternation to N channels and configurable sample width.
- Adds valid/ready flow control, frame buffering and start-of-frame resynchronisation.

---
 rtl/iq_sample_unpacker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/iq_sample_unpacker.sv
// Interleaved I/Q word stream to parallel per-channel frames, with a show-ahead frame FIFO.
// Optional statistics counters are built only when IQ_UNPACK_STATS_EN is defined; otherwise both read 0.
module iq_sample_unpacker #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter bit BYTE_SWAP  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SAMPLE_W-1:0]          in_data,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic [NUM_CH*SAMPLE_W-1:0]   out_i,
  output logic [NUM_CH*SAMPLE_W-1:0]   out_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  frame_count,
  output logic [15:0]                  drop_count
);

  localparam int WORDS  = 2 * NUM_CH;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NBYTES = SAMPLE_W / 8;
  localparam int FW     = NUM_CH * SAMPLE_W;

  logic [SAMPLE_W-1:0] word_sw;
  logic [IDX_W-1:0]    word_idx, word_idx_nxt, eff_idx;
  logic [FW-1:0]       asm_i, asm_q, asm_i_nxt, asm_q_nxt;
  logic [FW-1:0]       mem_i [FIFO_DEPTH];
  logic [FW-1:0]       mem_q [FIFO_DEPTH];
  logic [FW-1:0]       head_i_nxt, head_q_nxt;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]    count, count_nxt;
  logic                accept, resync, push, pop;

  generate
    if (BYTE_SWAP) begin : g_swap
      for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        assign word_sw[b*8 +: 8] = in_data[(NBYTES-1-b)*8 +: 8];
      end
    end else begin : g_pass
      assign word_sw = in_data;
    end
  endgenerate

  assign in_ready   = (count < CNT_W'(FIFO_DEPTH));
  assign accept     = in_valid && in_ready;
  assign resync     = accept && in_sof && (word_idx != '0);
  assign eff_idx    = resync ? '0 : word_idx;
  assign push       = accept && (eff_idx == IDX_W'(WORDS - 1));
  assign pop        = out_valid && out_ready;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // A resync clears the partial frame so stale samples never leak into the next one.
  always_comb begin
    asm_i_nxt    = resync ? '0 : asm_i;
    asm_q_nxt    = resync ? '0 : asm_q;
    word_idx_nxt = word_idx;
    if (accept) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (eff_idx == IDX_W'(2 * ch))     asm_i_nxt[ch*SAMPLE_W +: SAMPLE_W] = word_sw;
        if (eff_idx == IDX_W'(2 * ch + 1)) asm_q_nxt[ch*SAMPLE_W +: SAMPLE_W] = word_sw;
      end
      word_idx_nxt = push ? '0 : eff_idx + IDX_W'(1);
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  // Output registers track the head entry; they keep the last popped frame once empty.
  always_comb begin
    head_i_nxt = out_i;
    head_q_nxt = out_q;
    if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
      head_i_nxt = asm_i_nxt;
      head_q_nxt = asm_q_nxt;
    end else if (pop && (count > CNT_W'(1))) begin
      head_i_nxt = mem_i[rd_ptr_inc];
      head_q_nxt = mem_q[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_idx  <= '0;
      asm_i     <= '0;
      asm_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      word_idx  <= word_idx_nxt;
      asm_i     <= asm_i_nxt;
      asm_q     <= asm_q_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      out_i     <= head_i_nxt;
      out_q     <= head_q_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= asm_i_nxt;
      mem_q[wr_ptr] <= asm_q_nxt;
    end
  end

`ifdef IQ_UNPACK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (push) frame_count <= frame_count + 32'd1;
      if (resync && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule
